// File: rtl/pers_dispatch_pkg.sv
// Shared types and constants for the Wolverine personality dispatch controller.
package pers_dispatch_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int EXC_W         = 16;
  localparam int EXC_UNIMPL    = 0;
  localparam int EXC_IDX_RANGE = 1;
  localparam int EXC_WR_BUSY   = 2;

  localparam logic [4:0] START_OP_DEF = 5'd0;
endpackage

// File: rtl/pers_dispatch_if.sv
// Host dispatch port: instruction issue, AEG access, and status/return signals.
interface pers_dispatch_if;
  logic        disp_inst_vld;
  logic [4:0]  disp_inst;
  logic [17:0] disp_aeg_idx;
  logic        disp_aeg_rd;
  logic        disp_aeg_wr;
  logic [63:0] disp_aeg_wr_data;
  logic [17:0] disp_aeg_cnt;
  logic [15:0] disp_exception;
  logic        disp_idle;
  logic        disp_rtn_data_vld;
  logic [63:0] disp_rtn_data;
  logic        disp_stall;

  modport master (
    output disp_inst_vld, disp_inst, disp_aeg_idx, disp_aeg_rd, disp_aeg_wr, disp_aeg_wr_data,
    input  disp_aeg_cnt, disp_exception, disp_idle, disp_rtn_data_vld, disp_rtn_data, disp_stall
  );

  modport slave (
    input  disp_inst_vld, disp_inst, disp_aeg_idx, disp_aeg_rd, disp_aeg_wr, disp_aeg_wr_data,
    output disp_aeg_cnt, disp_exception, disp_idle, disp_rtn_data_vld, disp_rtn_data, disp_stall
  );
endinterface

// File: rtl/pers_dispatch_aeg_regfile.sv
// AEG register file: three prioritised write ports, one registered read port,
// and a flattened view of every register.
module aeg_regfile #(
  parameter int NUM_AEG = 16,
  parameter int CYC_AEG = NUM_AEG - 1,
  localparam int AW = $clog2(NUM_AEG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_wr,
  input  logic [AW-1:0]         host_idx,
  input  logic [63:0]           host_data,
  input  logic                  rslt_wr,
  input  logic [AW-1:0]         rslt_idx,
  input  logic [63:0]           rslt_data,
  input  logic                  cyc_wr,
  input  logic [63:0]           cyc_data,
  input  logic                  rd,
  input  logic                  rd_ok,
  input  logic [AW-1:0]         rd_idx,
  output logic                  rtn_vld,
  output logic [63:0]           rtn_data,
  output logic [NUM_AEG*64-1:0] aeg_out
);
  logic [63:0] aeg [NUM_AEG];

  // Cycle-count write beats unit result, which beats the host write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_AEG; i++) aeg[i] <= '0;
      rtn_vld  <= 1'b0;
      rtn_data <= '0;
    end else begin
      rtn_vld  <= rd;
      rtn_data <= (rd && rd_ok) ? aeg[rd_idx] : '0;
      for (int i = 0; i < NUM_AEG; i++) begin
        if (cyc_wr && i == CYC_AEG)                aeg[i] <= cyc_data;
        else if (rslt_wr && rslt_idx == AW'(i))    aeg[i] <= rslt_data;
        else if (host_wr && host_idx == AW'(i))    aeg[i] <= host_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_AEG; g++) begin : g_flat
    assign aeg_out[64*g +: 64] = aeg[g];
  end
endmodule

// File: rtl/pers_dispatch.sv
// Dispatch controller: decodes host instructions, launches and tracks the
// processing units, counts run cycles and reports exceptions.
module pers_dispatch
  import pers_dispatch_pkg::*;
#(
  parameter int         NUM_AEG   = 16,
  parameter int         NUM_UNITS = 1,
  parameter logic [4:0] START_OP  = START_OP_DEF,
  parameter int         CYC_AEG   = NUM_AEG - 1,
  localparam int        AW        = $clog2(NUM_AEG)
) (
  input  logic                  clk,
  input  logic                  i_reset,
  pers_dispatch_if.slave        disp,
  output logic [NUM_UNITS-1:0]  unit_start,
  input  logic [NUM_UNITS-1:0]  unit_done,
  output logic [NUM_AEG*64-1:0] aeg_out,
  input  logic                  rslt_wr_vld,
  input  logic [AW-1:0]         rslt_wr_idx,
  input  logic [63:0]           rslt_wr_data
);
  state_t               state, state_nxt;
  logic [63:0]          cyc_cnt;
  logic [NUM_UNITS-1:0] done_mask;
  logic [EXC_W-1:0]     exc;
  logic                 idle, stall;
  logic                 start_acc, cyc_wr;

  logic is_start, idx_ok, host_wr;
  assign is_start = disp.disp_inst_vld && (disp.disp_inst == START_OP);
  assign idx_ok   = disp.disp_aeg_idx < 18'(NUM_AEG);
  assign host_wr  = disp.disp_aeg_wr && idx_ok && (state == ST_IDLE);

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    cyc_wr    = 1'b0;
    case (state)
      ST_IDLE: if (is_start) begin
        state_nxt = ST_RUN;
        start_acc = 1'b1;
      end
      ST_RUN:  if (&(done_mask | unit_done)) state_nxt = ST_DONE;
      ST_DONE: begin
        state_nxt = ST_IDLE;
        cyc_wr    = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs follow the next state so they change on the same edge as state.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      cyc_cnt    <= '0;
      done_mask  <= '0;
      unit_start <= '0;
      exc        <= '0;
      idle       <= 1'b1;
      stall      <= 1'b0;
    end else begin
      state      <= state_nxt;
      unit_start <= {NUM_UNITS{start_acc}};
      idle       <= (state_nxt == ST_IDLE);
      stall      <= (state_nxt != ST_IDLE);
      if (start_acc) begin
        cyc_cnt   <= '0;
        done_mask <= '0;
      end else if (state == ST_RUN) begin
        if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 64'd1;
        done_mask <= done_mask | unit_done;
      end
      exc                <= '0;
      exc[EXC_UNIMPL]    <= disp.disp_inst_vld && !(is_start && state == ST_IDLE);
      exc[EXC_IDX_RANGE] <= (disp.disp_aeg_rd || disp.disp_aeg_wr) && !idx_ok;
      exc[EXC_WR_BUSY]   <= disp.disp_aeg_wr && idx_ok && (state != ST_IDLE);
    end
  end

  assign disp.disp_aeg_cnt   = 18'(NUM_AEG);
  assign disp.disp_exception = exc;
  assign disp.disp_idle      = idle;
  assign disp.disp_stall     = stall;

  aeg_regfile #(.NUM_AEG(NUM_AEG), .CYC_AEG(CYC_AEG)) u_regfile (
    .clk       (clk),
    .rst       (i_reset),
    .host_wr   (host_wr),
    .host_idx  (disp.disp_aeg_idx[AW-1:0]),
    .host_data (disp.disp_aeg_wr_data),
    .rslt_wr   (rslt_wr_vld),
    .rslt_idx  (rslt_wr_idx),
    .rslt_data (rslt_wr_data),
    .cyc_wr    (cyc_wr),
    .cyc_data  (cyc_cnt),
    .rd        (disp.disp_aeg_rd),
    .rd_ok     (idx_ok),
    .rd_idx    (disp.disp_aeg_idx[AW-1:0]),
    .rtn_vld   (disp.disp_rtn_data_vld),
    .rtn_data  (disp.disp_rtn_data),
    .aeg_out   (aeg_out)
  );
endmodule

// File: tb/tb_pers_dispatch.sv
// Randomised bench for pers_dispatch against a behavioural model, plus
// directed scenarios with hand-computed expectations.
module tb_pers_dispatch;
  localparam int         NA  = 16;
  localparam int         NU  = 4;
  localparam int         CA  = NA - 1;
  localparam logic [4:0] SOP = 5'd0;

  logic             clk, rst;
  logic [NU-1:0]    unit_start, unit_done;
  logic [NA*64-1:0] aeg_out;
  logic             rslt_wr_vld;
  logic [3:0]       rslt_wr_idx;
  logic [63:0]      rslt_wr_data;

  pers_dispatch_if bus();

  pers_dispatch #(.NUM_AEG(NA), .NUM_UNITS(NU), .START_OP(SOP), .CYC_AEG(CA)) dut (
    .clk          (clk),
    .i_reset      (rst),
    .disp         (bus),
    .unit_start   (unit_start),
    .unit_done    (unit_done),
    .aeg_out      (aeg_out),
    .rslt_wr_vld  (rslt_wr_vld),
    .rslt_wr_idx  (rslt_wr_idx),
    .rslt_wr_data (rslt_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 = idle, 1 = running, 2 = completion cycle.
  logic [63:0] m_aeg [NA];
  int          m_phase;
  logic [63:0] m_cnt;
  logic [NU-1:0] m_mask;
  bit          e_start, e_vld;
  logic [63:0] e_data;
  logic [15:0] e_exc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    logic [63:0] nxt [NA];
    int idx;
    bit in_rng, rd, wr;
    idx    = int'(bus.disp_aeg_idx);
    in_rng = idx < NA;
    rd     = bus.disp_aeg_rd;
    wr     = bus.disp_aeg_wr;
    if (rst) begin
      for (int i = 0; i < NA; i++) m_aeg[i] = '0;
      m_phase = 0; m_cnt = '0; m_mask = '0;
      e_start = 0; e_vld = 0; e_data = '0; e_exc = '0;
    end else begin
      e_exc  = '0;
      e_vld  = rd;
      e_data = (rd && in_rng) ? m_aeg[idx] : 64'd0;
      if (bus.disp_inst_vld && !(bus.disp_inst == SOP && m_phase == 0)) e_exc[0] = 1'b1;
      if ((rd || wr) && !in_rng) e_exc[1] = 1'b1;
      if (wr && in_rng && m_phase != 0) e_exc[2] = 1'b1;
      nxt = m_aeg;
      if (wr && in_rng && m_phase == 0) nxt[idx] = bus.disp_aeg_wr_data;
      if (rslt_wr_vld) nxt[rslt_wr_idx] = rslt_wr_data;
      e_start = 0;
      case (m_phase)
        0: if (bus.disp_inst_vld && bus.disp_inst == SOP) begin
          m_phase = 1; m_cnt = '0; m_mask = '0; e_start = 1;
        end
        1: begin
          if (m_cnt != '1) m_cnt = m_cnt + 1;
          m_mask = m_mask | unit_done;
          if (m_mask == '1) m_phase = 2;
        end
        default: begin
          nxt[CA] = m_cnt;
          m_phase = 0;
        end
      endcase
      m_aeg = nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("idle", 64'(bus.disp_idle), 64'(m_phase == 0));
      chk("stall", 64'(bus.disp_stall), 64'(m_phase != 0));
      chk("unit_start", 64'(unit_start), 64'({NU{e_start}}));
      chk("rtn_vld", 64'(bus.disp_rtn_data_vld), 64'(e_vld));
      if (e_vld) chk("rtn_data", bus.disp_rtn_data, e_data);
      chk("exception", 64'(bus.disp_exception), 64'(e_exc));
      chk("aeg_cnt", 64'(bus.disp_aeg_cnt), 64'(NA));
      for (int i = 0; i < NA; i++)
        chk($sformatf("aeg_out[%0d]", i), aeg_out[64*i +: 64], m_aeg[i]);
    end
  end

  task automatic clr();
    bus.disp_inst_vld = 0; bus.disp_inst = '0; bus.disp_aeg_idx = '0;
    bus.disp_aeg_rd = 0; bus.disp_aeg_wr = 0; bus.disp_aeg_wr_data = '0;
    unit_done = '0; rslt_wr_vld = 0; rslt_wr_idx = '0; rslt_wr_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_idle", 64'(bus.disp_idle), 64'd1);
    chk("rst_stall", 64'(bus.disp_stall), 64'd0);
    chk("rst_aeg_zero", 64'(|aeg_out), 64'd0);
    rst = 1'b0;

    // Host write then read back.
    bus.disp_aeg_wr = 1; bus.disp_aeg_idx = 18'd3; bus.disp_aeg_wr_data = 64'hDEAD_BEEF;
    tick(); clr();
    bus.disp_aeg_rd = 1; bus.disp_aeg_idx = 18'd3;
    tick(); clr();
    chk("rd3_vld", 64'(bus.disp_rtn_data_vld), 64'd1);
    chk("rd3_data", bus.disp_rtn_data, 64'hDEAD_BEEF);
    chk("rd3_exc", 64'(bus.disp_exception), 64'd0);

    // Four-unit run finishing in its tenth cycle.
    bus.disp_inst_vld = 1; bus.disp_inst = SOP;
    tick(); clr();
    chk("start_pulse", 64'(unit_start), 64'hF);
    chk("start_busy", 64'(bus.disp_idle), 64'd0);
    for (int k = 1; k <= 10; k++) begin
      unit_done = (k == 3) ? 4'b0101 : (k == 10) ? 4'b1010 : 4'b0000;
      tick();
    end
    clr();
    chk("done_busy", 64'(bus.disp_idle), 64'd0);
    tick();
    chk("run10_cyc", aeg_out[64*CA +: 64], 64'd10);
    chk("run10_idle", 64'(bus.disp_idle), 64'd1);

    // Minimum run: all units done in the first run cycle.
    bus.disp_inst_vld = 1; bus.disp_inst = SOP;
    tick(); clr();
    unit_done = 4'hF;
    tick(); clr();
    tick();
    chk("min_idle", 64'(bus.disp_idle), 64'd1);
    chk("min_cyc", aeg_out[64*CA +: 64], 64'd1);

    // Out-of-range read and unimplemented opcode.
    bus.disp_aeg_rd = 1; bus.disp_aeg_idx = 18'(NA);
    tick(); clr();
    chk("oor_vld", 64'(bus.disp_rtn_data_vld), 64'd1);
    chk("oor_data", bus.disp_rtn_data, 64'd0);
    chk("oor_exc", 64'(bus.disp_exception), 64'h2);
    tick();
    chk("oor_exc_clear", 64'(bus.disp_exception), 64'd0);
    bus.disp_inst_vld = 1; bus.disp_inst = 5'd5;
    tick(); clr();
    chk("unimpl_exc", 64'(bus.disp_exception), 64'h1);
    chk("unimpl_idle", 64'(bus.disp_idle), 64'd1);

    // Busy write dropped while a unit result lands on the same register.
    bus.disp_inst_vld = 1; bus.disp_inst = SOP;
    tick(); clr();
    bus.disp_aeg_wr = 1; bus.disp_aeg_idx = 18'd2; bus.disp_aeg_wr_data = 64'd7;
    rslt_wr_vld = 1; rslt_wr_idx = 4'd2; rslt_wr_data = 64'd9;
    tick(); clr();
    chk("busy_exc", 64'(bus.disp_exception), 64'h4);
    chk("busy_aeg2", aeg_out[64*2 +: 64], 64'd9);

    // Reset mid-run, then a stray unit_done.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_aeg_zero", 64'(|aeg_out), 64'd0);
    chk("abort_idle", 64'(bus.disp_idle), 64'd1);
    chk("abort_stall", 64'(bus.disp_stall), 64'd0);
    unit_done = 4'hF;
    tick(); clr();
    tick();
    chk("late_done_idle", 64'(bus.disp_idle), 64'd1);

    // Unit result beats host write in IDLE.
    bus.disp_aeg_wr = 1; bus.disp_aeg_idx = 18'd1; bus.disp_aeg_wr_data = 64'h1111;
    rslt_wr_vld = 1; rslt_wr_idx = 4'd1; rslt_wr_data = 64'h2222;
    tick(); clr();
    chk("prio_aeg1", aeg_out[64*1 +: 64], 64'h2222);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.disp_inst_vld    = ($urandom_range(0, 3) == 0);
      bus.disp_inst        = ($urandom_range(0, 1) == 0) ? SOP : 5'($urandom_range(0, 31));
      bus.disp_aeg_idx     = 18'($urandom_range(0, NA + 3));
      bus.disp_aeg_rd      = ($urandom_range(0, 2) == 0);
      bus.disp_aeg_wr      = ($urandom_range(0, 2) == 0);
      bus.disp_aeg_wr_data = {$urandom, $urandom};
      unit_done            = 4'($urandom & $urandom);
      rslt_wr_vld          = ($urandom_range(0, 3) == 0);
      rslt_wr_idx          = 4'($urandom_range(0, NA - 1));
      rslt_wr_data         = {$urandom, $urandom};
      tick();
    end
    rst = 1'b0;
    clr();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pers_dispatch.md
# pers_dispatch

Parametrised dispatch controller for a Wolverine personality: owns the NUM_AEG × 64-bit AEG register file, decodes dispatched instructions, and launches and tracks NUM_UNITS processing units. It generalises the fixed single-unit personality front-end with a sized AEG file, multi-unit start/done tracking, unit result write-back into AEGs, a run-cycle counter, and exception reporting. It sits between the personality top level's dispatch port and the compute units.

## Interface
- NUM_AEG, 16: number of AEG registers (2..256); reported on disp_aeg_cnt.
- NUM_UNITS, 1: number of processing units started and tracked (1..32).
- START_OP, 0: 5-bit opcode that launches a run.
- CYC_AEG, NUM_AEG-1: AEG index receiving the run cycle count at completion.

Ports:
- clk  in  1  personality clock.
- i_reset  in  1  synchronous, active-high reset.
- disp_inst_vld  in  1  instruction valid.
- disp_inst  in  5  opcode.
- disp_aeg_idx  in  18  AEG index.
- disp_aeg_rd / disp_aeg_wr  in  1  AEG read / write strobe.
- disp_aeg_wr_data  in  64  AEG write data.
- disp_aeg_cnt  out  18  constant NUM_AEG.
- disp_exception  out  16  exception pulses.
- disp_idle  out  1  high only in IDLE.
- disp_rtn_data_vld  out  1  read return valid.
- disp_rtn_data  out  64  read return data.
- disp_stall  out  1  high when not IDLE.
- unit_start  out  NUM_UNITS  one-cycle start pulse per unit.
- unit_done  in  NUM_UNITS  per-unit completion pulse.
- aeg_out  out  NUM_AEG*64  flattened AEG contents, AEG i at [64i+63:64i].
- rslt_wr_vld  in  1  unit result write strobe.
- rslt_wr_idx  in  $clog2(NUM_AEG)  result AEG index.
- rslt_wr_data  in  64  result data.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: disp_inst_vld with disp_inst==START_OP → unit_start all ones for one cycle, done_mask←0, cyc_cnt←0, go RUN.
- RUN: cyc_cnt += 1, saturating at 2^64-1; done_mask |= unit_done. When done_mask (including this cycle's unit_done) is all ones → DONE.
- DONE: AEG[CYC_AEG]←cyc_cnt; go IDLE next cycle.
- Opcode ≠ START_OP in any state, or START_OP outside IDLE: no state change; disp_exception[0] (UNIMPL) pulses.
- AEG write, idx < NUM_AEG, state IDLE: AEG[idx]←wr_data. Outside IDLE: write dropped; disp_exception[2] (WR_BUSY) pulses.
- AEG read: accepted in any state. idx ≥ NUM_AEG on read or write: no effect; read returns 0 with vld; disp_exception[1] (IDX_RANGE) pulses.
- Write priority on the same AEG in one cycle: DONE cycle-count write > rslt_wr > host write (the losing host write raises no exception).
- rslt_wr_vld is accepted in every state.
- Read and write to the same index in one cycle: the read returns the pre-write value.
- disp_inst_vld and an AEG strobe in the same cycle are both processed.
- disp_exception[15:3] are tied to 0.

## Timing
- Reset: all AEGs 0; state IDLE; cyc_cnt 0; done_mask 0; unit_start 0; disp_rtn_data_vld 0; disp_rtn_data 0; disp_exception 0; disp_idle 1; disp_stall 0.
- Reset asserted mid-run aborts the run. No unit_start is issued. Late unit_done pulses are ignored in IDLE.
- Read latency 1: disp_rtn_data_vld and disp_rtn_data are registered and valid in the cycle after disp_aeg_rd.
- Exception pulses are registered, one cycle after the cause, one cycle wide.
- unit_start is asserted in the first RUN cycle. disp_idle and disp_stall are registered from the state and change on the same edge.
- Minimum run with unit_done in the first RUN cycle: RUN 1 cycle, DONE 1 cycle, disp_idle high 2 cycles after start accept. CYC_AEG holds 1.
- aeg_out reflects register contents with no extra latency.

## Structure
- Package pers_dispatch_pkg holds the state enum, exception bit positions (EXC_UNIMPL=0, EXC_IDX_RANGE=1, EXC_WR_BUSY=2), and the START_OP default.
- Sub-module aeg_regfile contains the register array, 3-way write priority, registered read port, and aeg_out flattening.
- The FSM, counter and exception logic live in pers_dispatch.

## Test plan
- Write AEG3=0xDEAD_BEEF in IDLE, then read AEG3 → next cycle vld=1, data=0xDEADBEEF, no exception.
- NUM_UNITS=4: START_OP; unit_done bits 0,2 at cycle 3 and bits 1,3 at cycle 10 → DONE after cycle 10; AEG[CYC_AEG]=10; disp_idle returns.
- Read idx=NUM_AEG → data 0, vld=1, exception[1] one-cycle pulse; opcode 5 → exception[0] pulse, state unchanged.
- During RUN: host write AEG2=7 → dropped, exception[2] pulses. Same cycle rslt_wr AEG2=9 → AEG2=9.
- i_reset mid-RUN → next cycle all AEGs 0, disp_idle=1, disp_stall=0. A later unit_done causes no transition.
- rslt_wr and host write to AEG1 in the same IDLE cycle → AEG1 holds rslt_wr_data.
